// File: rtl/conv_stream_scheduler_pkg.sv
// conv_pkg: shared state encoding for the convolution stream scheduler.
package conv_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/conv_stream_scheduler_tag_pipe.sv
// tag_pipe: fixed-latency shift register of {valid, row, col} output tags.
// Row/col only advance behind valid tags so the output coordinates hold across bubbles.
module tag_pipe #(
    parameter int DEPTH = 2,
    parameter int RW    = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [RW-1:0] in_row,
    input  logic [CW-1:0] in_col,
    output logic          out_valid,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col
);
    logic [DEPTH-1:0] v;
    logic [RW-1:0]    r [DEPTH];
    logic [CW-1:0]    c [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r[i] <= '0;
                c[i] <= '0;
            end
        end else begin
            v[0] <= flush ? 1'b0 : in_valid;
            r[0] <= in_valid ? in_row : r[0];
            c[0] <= in_valid ? in_col : c[0];
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= flush ? 1'b0 : v[i-1];
                r[i] <= r[i-1];
                c[i] <= c[i-1];
            end
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_row   = r[DEPTH-1];
    assign out_col   = c[DEPTH-1];
endmodule

// File: rtl/conv_stream_scheduler.sv
// conv_stream_scheduler: paces one frame of pixels into the PE array, tags valid
// conv windows with latency-aligned coordinates, and reports done/underrun.
module conv_stream_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int KSIZE    = 3,
    parameter int PIPE_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_pix_valid,
    output logic                     o_pix_ready,
    output logic                     o_out_valid,
    output logic [$clog2(IMG_H)-1:0] o_out_row,
    output logic [$clog2(IMG_W)-1:0] o_out_col,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_underrun
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int DW = $clog2(PIPE_LAT + 1);

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [DW-1:0] drain_cnt;
    logic          accept, underrun, last_col, last_pix, tag_valid;

    assign o_pix_ready = state == STREAM;
    assign o_busy      = state != IDLE;
    assign o_done      = state == DONE;
    assign accept      = o_pix_ready & i_pix_valid;
    assign underrun    = o_pix_ready & ~i_pix_valid;
    assign last_col    = col == CW'(IMG_W - 1);
    assign last_pix    = last_col && row == RW'(IMG_H - 1);
    assign tag_valid   = accept && row >= RW'(KSIZE - 1) && col >= CW'(KSIZE - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            drain_cnt  <= '0;
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= underrun;
            case (state)
                IDLE: begin
                    row <= '0;
                    col <= '0;
                    if (i_start) state <= STREAM;
                end
                STREAM: begin
                    if (underrun) begin
                        state <= IDLE;
                    end else begin
                        col <= last_col ? '0 : col + CW'(1);
                        if (last_col) row <= last_pix ? '0 : row + RW'(1);
                        if (last_pix) begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(PIPE_LAT - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) state <= DONE;
                    else drain_cnt <= drain_cnt - DW'(1);
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    tag_pipe #(.DEPTH(PIPE_LAT), .RW(RW), .CW(CW)) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (underrun),
        .in_valid (tag_valid),
        .in_row   (row - RW'(KSIZE - 1)),
        .in_col   (col - CW'(KSIZE - 1)),
        .out_valid(o_out_valid),
        .out_row  (o_out_row),
        .out_col  (o_out_col)
    );
endmodule

// File: tb/tb_conv_stream_scheduler.sv
// tb_conv_stream_scheduler: table-driven checks on a 4x4 instance plus a full
// default-size frame on a second instance.
module tb_conv_stream_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st4 = 1'b0, pv4 = 1'b0;
    logic       rdy4, ov4, busy4, done4, und4;
    logic [1:0] row4, col4;
    logic       st28 = 1'b0, pv28 = 1'b0;
    logic       rdy28, ov28, busy28, done28, und28;
    logic [4:0] row28, col28;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic start, pv;
        int   rdy, ov, busy, done, und, chk_rc, row, col;
    } vec_t;

    always #5 clk = ~clk;

    conv_stream_scheduler #(.IMG_W(4), .IMG_H(4), .KSIZE(3), .PIPE_LAT(2)) u4 (
        .clk(clk), .rst(rst), .i_start(st4), .i_pix_valid(pv4),
        .o_pix_ready(rdy4), .o_out_valid(ov4), .o_out_row(row4), .o_out_col(col4),
        .o_busy(busy4), .o_done(done4), .o_underrun(und4)
    );

    conv_stream_scheduler u28 (
        .clk(clk), .rst(rst), .i_start(st28), .i_pix_valid(pv28),
        .o_pix_ready(rdy28), .o_out_valid(ov28), .o_out_row(row28), .o_out_col(col28),
        .o_busy(busy28), .o_done(done28), .o_underrun(und28)
    );

    task automatic chk(input string name, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input int c);
        chk({tag, " ready"}, c, int'(rdy4), 0);
        chk({tag, " out_valid"}, c, int'(ov4), 0);
        chk({tag, " row"}, c, int'(row4), 0);
        chk({tag, " col"}, c, int'(col4), 0);
        chk({tag, " busy"}, c, int'(busy4), 0);
        chk({tag, " done"}, c, int'(done4), 0);
        chk({tag, " underrun"}, c, int'(und4), 0);
    endtask

    task automatic apply(input vec_t v, input string tag, input int c);
        st4 = v.start;
        pv4 = v.pv;
        @(negedge clk);
        chk({tag, " ready"}, c, int'(rdy4), v.rdy);
        chk({tag, " out_valid"}, c, int'(ov4), v.ov);
        chk({tag, " busy"}, c, int'(busy4), v.busy);
        chk({tag, " done"}, c, int'(done4), v.done);
        chk({tag, " underrun"}, c, int'(und4), v.und);
        if (v.chk_rc != 0) begin
            chk({tag, " row"}, c, int'(row4), v.row);
            chk({tag, " col"}, c, int'(col4), v.col);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t nom(input int c);
        vec_t v;
        v.start  = c == 0;
        v.pv     = 1'b1;
        v.rdy    = (c >= 1 && c <= 16) ? 1 : 0;
        v.ov     = (c == 13 || c == 14 || c == 17 || c == 18) ? 1 : 0;
        v.busy   = (c >= 1 && c <= 19) ? 1 : 0;
        v.done   = c == 19 ? 1 : 0;
        v.und    = 0;
        v.chk_rc = c >= 13 ? 1 : 0;
        v.row    = c >= 17 ? 1 : 0;
        v.col    = (c >= 14 && c != 17) ? 1 : 0;
        return v;
    endfunction

    task automatic run_underrun(input vec_t tbl[21], input int drop, input string tag);
        vec_t v;
        for (int c = 0; c <= drop + 8; c++) begin
            v = tbl[c];
            v.chk_rc = 0;
            if (c == drop) begin
                v.pv = 1'b0;
            end else if (c > drop) begin
                v.rdy = 0; v.ov = 0; v.busy = 0; v.done = 0;
                v.und = c == drop + 1 ? 1 : 0;
            end
            apply(v, tag, c);
        end
    endtask

    initial begin
        vec_t tbl[21];
        vec_t ign[21];
        vec_t z;
        int   acc, n_ov, first_ov, last_ov, done_c, lr, lc;
        for (int c = 0; c < 21; c++) begin
            tbl[c] = nom(c);
            ign[c] = tbl[c];
        end
        ign[5].start  = 1'b1;
        ign[17].start = 1'b1;
        z = nom(20);
        z.chk_rc = 0;

        @(negedge clk);
        chk_zero("reset", 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c < 20; c++) apply(tbl[c], "nominal", c);
        for (int c = 0; c < 21; c++) apply(tbl[c], "back2back", c);
        for (int c = 0; c < 21; c++) apply(ign[c], "start_ignored", c);
        for (int c = 21; c < 24; c++) apply(z, "single_done", c);

        run_underrun(tbl, 6, "underrun6");
        run_underrun(tbl, 12, "underrun_flush");

        for (int c = 0; c < 12; c++) apply(tbl[c], "pre_reset", c);
        rst = 1'b1;
        #1;
        chk_zero("mid_reset", 12);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply(z, "post_reset", 13);
        for (int c = 0; c < 21; c++) apply(tbl[c], "restart", c);

        acc = 0; n_ov = 0; first_ov = -1; last_ov = -1; done_c = -1; lr = -1; lc = -1;
        st28 = 1'b1;
        pv28 = 1'b1;
        for (int c = 0; c < 900 && done_c < 0; c++) begin
            @(negedge clk);
            if (rdy28) acc++;
            if (ov28) begin
                n_ov++;
                if (first_ov < 0) begin
                    first_ov = c;
                    chk("full first_row", c, int'(row28), 0);
                    chk("full first_col", c, int'(col28), 0);
                end
                last_ov = c;
                lr = int'(row28);
                lc = int'(col28);
            end
            if (und28) chk("full underrun", c, 1, 0);
            if (done28) done_c = c;
            @(posedge clk);
            #1;
            st28 = 1'b0;
        end
        chk("full accepts", 0, acc, 784);
        chk("full out_count", 0, n_ov, 676);
        chk("full first_ov_cycle", 0, first_ov, 61);
        chk("full last_ov_cycle", 0, last_ov, 786);
        chk("full last_row", 0, lr, 25);
        chk("full last_col", 0, lc, 25);
        chk("full done_cycle", 0, done_c, 787);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
